// File: rtl/dot_channel_seq.sv
// Sequencer for one dot_channel datapath: per position, raise load, step the weight
// chip-select, wait for the channel result, then hand it downstream over valid/ready.
// Optional watchdog enabled by defining DOT_SEQ_TIMEOUT_EN.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module dot_channel_seq #(
  parameter int unsigned N_CS    = 12,
  parameter int unsigned POS_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [POS_W-1:0]     n_pos,
  output logic                 busy,
  output logic                 done,
  output logic [POS_W-1:0]     pos_idx,
  output logic                 ch_load,
  output logic [3:0]           ch_cs,
  input  logic                 ch_valid,
  input  logic [`DATA_LEN-1:0] ch_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [`DATA_LEN-1:0] out_data,
  output logic [POS_W-1:0]     out_idx,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  localparam logic [3:0] CS_MAX = 4'(N_CS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [POS_W-1:0]     r_n_pos;
  logic [POS_W-1:0]     r_pos_idx;
  logic [POS_W-1:0]     r_out_idx;
  logic [3:0]           r_cs;
  logic [`DATA_LEN-1:0] r_out_data;
  logic                 r_done;

  logic w_start_ok;
  logic w_start_empty;
  logic w_capture;
  logic w_accept;
  logic w_last;
  logic w_timeout;

  assign w_start_ok    = (r_state == S_IDLE) && start && (n_pos != '0);
  assign w_start_empty = (r_state == S_IDLE) && start && (n_pos == '0);
  assign w_capture     = (r_state == S_RUN) && ch_valid;
  assign w_accept      = (r_state == S_OUT) && out_ready;
  // n_pos is latched non-zero, so the subtraction cannot wrap
  assign w_last        = (r_pos_idx == (r_n_pos - POS_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    ch_load   = 1'b0;
    ch_cs     = '0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        ch_load = 1'b1;
        ch_cs   = r_cs;
        if (w_capture) begin
          w_next = S_OUT;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_accept) begin
          w_next = w_last ? S_IDLE : S_RUN;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_pos    <= '0;
      r_pos_idx  <= '0;
      r_out_idx  <= '0;
      r_out_data <= '0;
      r_cs       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start_empty) begin
        r_done <= 1'b1;
      end
      if (w_start_ok) begin
        r_n_pos   <= n_pos;
        r_pos_idx <= '0;
        r_cs      <= '0;
      end
      if ((r_state == S_RUN) && (r_cs != CS_MAX)) begin
        r_cs <= r_cs + 4'd1;
      end
      if (w_capture) begin
        r_out_data <= ch_q;
        r_out_idx  <= r_pos_idx;
      end
      if (w_timeout) begin
        r_done <= 1'b1;
      end
      if (w_accept) begin
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_pos_idx <= r_pos_idx + POS_W'(1);
          r_cs      <= '0;
        end
      end
    end
  end

`ifdef DOT_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_err;

  // r_wd counts RUN cycles already spent; the last allowed cycle is TIMEOUT-1
  assign w_timeout = (r_state == S_RUN) && !ch_valid && (r_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start_ok || w_accept) begin
        r_wd <= '0;
      end else if (r_state == S_RUN) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if ((r_state == S_IDLE) && start) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  assign done     = r_done;
  assign pos_idx  = r_pos_idx;
  assign out_data = r_out_data;
  assign out_idx  = r_out_idx;

endmodule

// File: tb/tb_dot_channel_seq.sv
// Bench for dot_channel_seq: channel model, transaction-level reference checked every
// cycle, plus directed scenarios with hand-computed expectations.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module tb_dot_channel_seq;

  localparam int unsigned N_CS    = 12;
  localparam int unsigned POS_W   = 16;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DW      = `DATA_LEN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [POS_W-1:0]  n_pos = '0;
  logic              busy, done, ch_load, out_valid, err;
  logic [POS_W-1:0]  pos_idx, out_idx;
  logic [3:0]        ch_cs;
  logic              ch_valid;
  logic [DW-1:0]     ch_q;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;

  dot_channel_seq #(.N_CS(N_CS), .POS_W(POS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_pos(n_pos),
    .busy(busy), .done(done), .pos_idx(pos_idx), .ch_load(ch_load), .ch_cs(ch_cs),
    .ch_valid(ch_valid), .ch_q(ch_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Channel result as seen through the input mux for position p
  function automatic logic [DW-1:0] dfn(input logic [POS_W-1:0] p, input logic [31:0] s);
    return DW'(s ^ {p, ~p});
  endfunction

  // ---------------- channel model ----------------
  logic [31:0] salt = 32'h0;
  bit          ch_en = 1'b1;
  bit          ch_force = 1'b0;
  int unsigned ch_lat = 13;
  int unsigned c_cnt;
  bit          c_prev;

  initial begin
    ch_valid = 1'b0;
    ch_q     = '0;
    c_cnt    = 0;
    c_prev   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ch_load) c_cnt = c_prev ? c_cnt + 1 : 0;
      else c_cnt = 0;
      c_prev   = ch_load;
      ch_valid = ch_force || (ch_en && ch_load && (c_cnt >= ch_lat));
      ch_q     = ch_force ? DW'(32'hDEAD_BEEF) : dfn(pos_idx, salt);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_active = 0, m_out = 0, m_done_due = 0, m_err = 0;
  int unsigned m_npos = 0, m_beats = 0, m_k = 0;
  int unsigned obs_beats = 0, obs_done = 0, obs_busy = 0, obs_busy_noload = 0, obs_load = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_load", ch_load, 0);
      chk("rst_ovalid", out_valid, 0);
      chk("rst_pos_idx", pos_idx, 0);
      chk("rst_err", err, 0);
      m_active = 0; m_out = 0; m_done_due = 0; m_err = 0;
    end else begin
      chk("busy", busy, m_active);
      chk("done", done, m_done_due);
      chk("err", err, m_err);
      if (!m_active) begin
        chk("load_idle", ch_load, 0);
        chk("ovalid_idle", out_valid, 0);
      end else begin
        chk("pos_idx", pos_idx, m_beats);
        chk("out_valid", out_valid, m_out);
        chk("ch_load", ch_load, !m_out);
        if (m_out) begin
          chk("out_idx", out_idx, m_beats);
          chk("out_data", out_data, dfn(POS_W'(m_beats), salt));
        end else begin
          chk("ch_cs", ch_cs, (m_k < N_CS - 1) ? m_k : N_CS - 1);
        end
      end
      if (out_valid && out_ready) obs_beats++;
      if (done) obs_done++;
      if (busy) obs_busy++;
      if (busy && !ch_load) obs_busy_noload++;
      if (ch_load) obs_load++;
      m_done_due = 0;
      if (m_active) begin
        if (!m_out) begin
          if (ch_valid) m_out = 1;
          else begin
            m_k++;
`ifdef DOT_SEQ_TIMEOUT_EN
            if (m_k == TIMEOUT) begin
              m_active = 0; m_done_due = 1; m_err = 1;
            end
`endif
          end
        end else if (out_ready) begin
          m_beats++;
          m_out = 0;
          m_k   = 0;
          if (m_beats == m_npos) begin
            m_active = 0; m_done_due = 1;
          end
        end
      end else if (start) begin
        m_err = 0;
        if (n_pos == '0) m_done_due = 1;
        else begin
          m_active = 1; m_npos = n_pos; m_beats = 0; m_k = 0; m_out = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned s_beats, s_done, s_busy, s_busy_noload, s_load;

  task automatic snap();
    s_beats = obs_beats; s_done = obs_done; s_busy = obs_busy;
    s_busy_noload = obs_busy_noload; s_load = obs_load;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned np);
    n_pos = POS_W'(np);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int unsigned lat);
    lat = 0;
    while (!done && lat < 500) begin
      step();
      lat++;
    end
    chk("done_seen", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  int unsigned lat;
  int unsigned n;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_pos", pos_idx, 0);
    chk("reset_data", out_data, 0);
    chk("reset_cs", ch_cs, 0);
    rst_n = 1'b1;
    step();

    // three positions, nominal channel latency, downstream always ready
    salt = 32'h1234_0000; ch_lat = 13; snap();
    pulse(3);
    wait_done(lat);
    chk("t1_latency", lat, 45);
    step();
    chk("t1_done_single", done, 0);
    chk("t1_beats", obs_beats - s_beats, 3);
    chk("t1_done_count", obs_done - s_done, 1);
    chk("t1_load_cycles", obs_load - s_load, 42);
    chk("t1_load_gaps", obs_busy_noload - s_busy_noload, 3);
    chk("t1_last_data", out_data, 32'h1236_FFFD);
    chk("t1_last_idx", out_idx, 2);

    // empty layer
    snap();
    pulse(0);
    wait_done(lat);
    chk("t2_latency", lat, 0);
    step();
    chk("t2_busy", obs_busy - s_busy, 0);
    chk("t2_load", obs_load - s_load, 0);
    chk("t2_done_count", obs_done - s_done, 1);

    // back-pressure with stray channel valid while holding
    salt = 32'hA5A5_0000; out_ready = 1'b0; snap();
    pulse(2);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk("t3_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_idx", out_idx, 0);
      chk("t3_hold_pos", pos_idx, 0);
      chk("t3_hold_load", ch_load, 0);
      chk("t3_hold_data", out_data, 32'hA5A5_FFFF);
      ch_force = (i == 1 || i == 2);
      step();
    end
    ch_force = 1'b0;
    out_ready = 1'b1;
    wait_done(lat);
    step();
    chk("t3_beats", obs_beats - s_beats, 2);
    chk("t3_last_data", out_data, 32'hA5A4_FFFE);

    // start and n_pos changes while busy are ignored
    salt = 32'h0F0F_0000; snap();
    pulse(2);
    repeat (5) step();
    n_pos = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
    step();
    chk("t4_beats", obs_beats - s_beats, 2);
    chk("t4_last_idx", out_idx, 1);

    // slow and fast channels
    salt = 32'h3C3C_0000; ch_lat = 20;
    pulse(2);
    wait_done(lat);
    chk("t5_slow_latency", lat, 44);
    step();
    ch_lat = 3; snap();
    pulse(4);
    wait_done(lat);
    chk("t5_fast_latency", lat, 20);
    step();
    chk("t5_fast_beats", obs_beats - s_beats, 4);

    // asynchronous reset in the middle of RUN
    salt = 32'h7777_0000; ch_lat = 13;
    pulse(3);
    n = 0;
    while (!(ch_load && ch_cs == 4'd5) && n < 50) begin step(); n++; end
    chk("t6_cs5_seen", ch_cs, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_pos", pos_idx, 0);
    chk("t6_load", ch_load, 0);
    chk("t6_cs", ch_cs, 0);
    chk("t6_ovalid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_idx", out_idx, 0);
    chk("t6_err", err, 0);
    snap();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("t6_no_done", obs_done - s_done, 0);
    snap();
    pulse(2);
    chk("t6_restart_pos", pos_idx, 0);
    wait_done(lat);
    chk("t6_restart_latency", lat, 30);
    step();
    chk("t6_restart_beats", obs_beats - s_beats, 2);

`ifdef DOT_SEQ_TIMEOUT_EN
    // channel never answers
    ch_en = 1'b0;
    pulse(1);
    wait_done(lat);
    chk("t7_timeout_latency", lat, 64);
    chk("t7_err", err, 1);
    chk("t7_load", ch_load, 0);
    chk("t7_busy", busy, 0);
    step();
    chk("t7_err_sticky", err, 1);
    ch_en = 1'b1;
    pulse(0);
    chk("t7_err_cleared", err, 0);
    chk("t7_done", done, 1);
    step();
`endif

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dot_channel_seq.md
Name: dot_channel_seq

Overview:
- Sequencer for one dot_channel-style datapath (weight store plus 288-wide inner product).
- For each of n_pos input positions it raises the channel load, steps the weight chip-select 0..N_CS-1, and waits for the channel valid.
- It then captures the channel result and hands it downstream over a valid/ready handshake.
- Sits between the layer controller (start/done) and one channel instance; the input-vector mux is steered by pos_idx.

Parameters:
- N_CS, 12, number of weight chunks per dot product; ch_cs steps 0..N_CS-1 (N_CS <= 16).
- POS_W, 16, width of the position count and index.
- TIMEOUT, 64, watchdog limit in cycles (used only with DOT_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to run a layer; sampled only in IDLE.
- n_pos  in  POS_W  positions to process; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse when the layer completes.
- pos_idx  out  POS_W  index of the position currently presented to the channel.
- ch_load  out  1  channel load.
- ch_cs  out  4  weight chip-select.
- ch_valid  in  1  channel result valid.
- ch_q  in  `data_len  channel result.
- out_valid  out  1  result valid to downstream.
- out_ready  in  1  downstream accept.
- out_data  out  `data_len  captured result.
- out_idx  out  POS_W  position index of out_data.
- err  out  1  sticky watchdog error; constant 0 without DOT_SEQ_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States and transitions:
  - IDLE: ch_load=0. On start=1:
    - n_pos==0: next cycle done=1, busy stays 0, remain IDLE.
    - otherwise: latch n_pos, pos_idx=0, go to RUN.
  - RUN:
    - ch_load=1 and ch_cs=cs_cnt.
    - cs_cnt starts at 0 on RUN entry, increments by 1 each cycle, and saturates at N_CS-1.
    - On ch_valid=1 with ch_load=1: capture out_data<=ch_q and out_idx<=pos_idx, then go to OUT.
  - OUT: ch_load=0, out_valid=1. On out_ready=1:
    - out_valid drops next cycle.
    - If pos_idx==n_pos_latched-1: done pulses for 1 cycle, busy drops, go to IDLE.
    - Otherwise pos_idx+1, cs_cnt=0, go to RUN.
- Load edge rule: OUT lasts at least 1 cycle, so ch_load is always low for at least 1 cycle between positions. This guarantees the channel sees a 0->1 load edge and re-initialises its internal count.
- Nominal latency: first ch_valid expected N_CS+1 cycles after RUN entry. The sequencer does not assume this value; it waits for ch_valid.
- ch_valid is ignored outside RUN.
- Back-pressure: in OUT, out_data and out_idx are held stable while out_ready=0.
- start outside IDLE is ignored and has no side effects.
- A change of n_pos while busy has no effect.
- Reset asserted mid-operation returns everything to reset values immediately; no done pulse.
- pos_idx arithmetic is modulo 2^POS_W; n_pos=2^POS_W-1 completes without wrap.

Optional Feature:
- Macro: DOT_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on RUN entry and increments each RUN cycle.
  - If it reaches TIMEOUT without ch_valid: err<=1 (sticky until reset or the next accepted start), done pulses, busy drops, return to IDLE with ch_load=0.
- Undefined: no watchdog; RUN waits indefinitely; err tied to 0.

Test Plan:
- Reset, then start with n_pos=3, out_ready=1, and a channel model asserting valid 13 cycles after the load rise.
  -> Exactly 3 out_valid beats with out_idx 0,1,2.
  -> ch_cs sequence 0..11 within each load window.
  -> ch_load low exactly 1 cycle between positions.
  -> done a single pulse after the third beat.
- n_pos=0, start -> done pulses next cycle; busy never high; ch_load never high.
- n_pos=2, out_ready held 0 for 5 cycles on the first result.
  -> out_data and out_idx=0 stable for those cycles.
  -> ch_load stays 0 and pos_idx stays 0 until the accept.
- start pulsed again during RUN -> ignored; total out_valid beats still equals the original n_pos.
- rst_n pulled low in the middle of RUN with cs=5 -> all outputs 0 asynchronously; no done; a new start runs a clean sequence from pos 0.
- With DOT_SEQ_TIMEOUT_EN, TIMEOUT=64, channel never asserts valid.
  -> err=1 and done pulse 64 cycles after RUN entry; ch_load=0 afterwards.
  -> A following start clears err.
